// File: rtl/dsp_result_misr_pkg.sv
// ---------------------------------------------------------------------------
// dsp_result_misr_pkg
// Shared definitions for the multiplier-result MISR block and anything that
// needs to model it (for example the upstream stimulus checker):
//   - MISR width
//   - feedback tap positions
//   - default seed
//   - controller state encoding
// ---------------------------------------------------------------------------
package dsp_result_misr_pkg;

    localparam int MISR_W = 48;

    // Feedback taps of the 48-bit signature register
    localparam int TAP_A = 47;
    localparam int TAP_B = 46;
    localparam int TAP_C = 20;
    localparam int TAP_D = 19;

    localparam logic [MISR_W-1:0] DEFAULT_SEED = 48'h0000_0000_0001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_ACCUM = 2'd2,
        ST_DONE  = 2'd3
    } misr_state_e;

endpackage

// File: rtl/misr48_step.sv
// ---------------------------------------------------------------------------
// misr48_step
// One purely combinational step of the 48-bit MISR:
//   fb     = m[47] ^ m[46] ^ m[20] ^ m[19]
//   m_next = {m[46:0], fb} ^ d
// Ports:
//   m_i       current MISR value
//   d_i       data word absorbed this step
//   m_next_o  next MISR value
// ---------------------------------------------------------------------------
module misr48_step
    import dsp_result_misr_pkg::*;
(
    input  logic [MISR_W-1:0] m_i,
    input  logic [MISR_W-1:0] d_i,
    output logic [MISR_W-1:0] m_next_o
);

    logic feedback;

    // Shift left, feed the XOR of the taps into bit 0, then fold in the data
    assign feedback = m_i[TAP_A] ^ m_i[TAP_B] ^ m_i[TAP_C] ^ m_i[TAP_D];
    assign m_next_o = {m_i[MISR_W-2:0], feedback} ^ d_i;

endmodule

// File: rtl/dsp_result_misr.sv
// ---------------------------------------------------------------------------
// dsp_result_misr
// Compresses a window of WIN_LEN valid multiplier products into a 48-bit MISR
// signature. After START, LAT cycles are skipped so that products still in
// flight in the upstream multiplier pipeline are not absorbed.
//
// Parameters:
//   WIN_LEN  valid samples absorbed per window (1 .. 2^24)
//   LAT      cycles skipped after START (0 allowed)
//   SEED     MISR value loaded at START
//
// Ports:
//   CLK         system clock, rising edge
//   RST         synchronous active-high reset
//   START       begin a window (accepted only in IDLE or DONE)
//   ABORT       return to IDLE at the next edge, no DONE pulse
//   DATA_VALID  qualifies DATA_IN during accumulation
//   DATA_IN     48-bit product word
//   BUSY        high while priming or accumulating
//   DONE        one-cycle pulse when SIGNATURE has just been updated
//   SIGNATURE   last completed signature
//   SAMPLE_CNT  valid samples absorbed in the current or last window
//
// Optional build macro DSP_MISR_CMP_EN adds:
//   EXPECTED_SIG  reference signature compared at the end of each window
//   MISMATCH      sticky flag, set when a finished window differs from
//                 EXPECTED_SIG, cleared by START or RST
//   PASS_CNT      saturating count of matching windows
// ---------------------------------------------------------------------------
module dsp_result_misr
    import dsp_result_misr_pkg::*;
#(
    parameter int unsigned       WIN_LEN = 1024,
    parameter int unsigned       LAT     = 6,
    parameter logic [MISR_W-1:0] SEED    = DEFAULT_SEED
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              ABORT,
    input  logic              DATA_VALID,
    input  logic [MISR_W-1:0] DATA_IN,
`ifdef DSP_MISR_CMP_EN
    input  logic [MISR_W-1:0] EXPECTED_SIG,
    output logic              MISMATCH,
    output logic [15:0]       PASS_CNT,
`endif
    output logic              BUSY,
    output logic              DONE,
    output logic [MISR_W-1:0] SIGNATURE,
    output logic [23:0]       SAMPLE_CNT
);

    // One extra counter bit so that WIN_LEN = 2^24 is representable
    localparam int CNT_W  = 25;
    localparam int SKIP_W = (LAT < 2) ? 1 : $clog2(LAT + 1);

    localparam logic [CNT_W-1:0]  WIN_LAST  = CNT_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0]  WIN_FULL  = CNT_W'(WIN_LEN);
    localparam logic [SKIP_W-1:0] SKIP_INIT = SKIP_W'(LAT);
    localparam misr_state_e       FIRST_ST  = (LAT == 0) ? ST_ACCUM : ST_PRIME;

    misr_state_e       state_q;
    logic [SKIP_W-1:0] skipCnt_q;
    logic [CNT_W-1:0]  sampleCnt_q;
    logic [MISR_W-1:0] misr_q;
    logic [MISR_W-1:0] misr_d;
    logic [MISR_W-1:0] signature_q;
    logic              busy_q;
    logic              done_q;
`ifdef DSP_MISR_CMP_EN
    logic              mismatch_q;
    logic [15:0]       passCnt_q;
`endif

    // Next MISR value if the current DATA_IN were absorbed this cycle
    misr48_step u_step (
        .m_i      (misr_q),
        .d_i      (DATA_IN),
        .m_next_o (misr_d)
    );

    // Window controller. BUSY and DONE are registered alongside the state so
    // they are glitch-free. SIGNATURE is loaded on the same edge that enters
    // DONE, so it is already final while the DONE pulse is high.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            skipCnt_q   <= '0;
            sampleCnt_q <= '0;
            misr_q      <= SEED;
            signature_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef DSP_MISR_CMP_EN
            mismatch_q  <= 1'b0;
            passCnt_q   <= '0;
`endif
        end else if (ABORT) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        misr_q      <= SEED;
                        sampleCnt_q <= '0;
                        skipCnt_q   <= SKIP_INIT;
                        state_q     <= FIRST_ST;
                        busy_q      <= 1'b1;
`ifdef DSP_MISR_CMP_EN
                        mismatch_q  <= 1'b0;
`endif
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_PRIME: begin
                    skipCnt_q <= skipCnt_q - 1'b1;
                    if (skipCnt_q == SKIP_W'(1)) begin
                        state_q <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (DATA_VALID) begin
                        misr_q <= misr_d;
                        if (sampleCnt_q != WIN_FULL) begin
                            sampleCnt_q <= sampleCnt_q + 1'b1;
                        end
                        if (sampleCnt_q == WIN_LAST) begin
                            state_q     <= ST_DONE;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            signature_q <= misr_d;
`ifdef DSP_MISR_CMP_EN
                            mismatch_q  <= (misr_d != EXPECTED_SIG);
                            if ((misr_d == EXPECTED_SIG) && (passCnt_q != 16'hFFFF)) begin
                                passCnt_q <= passCnt_q + 1'b1;
                            end
`endif
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign SIGNATURE  = signature_q;
    // Only reachable with WIN_LEN = 2^24: clamp instead of wrapping to 0
    assign SAMPLE_CNT = sampleCnt_q[CNT_W-1] ? 24'hFF_FFFF : sampleCnt_q[23:0];
`ifdef DSP_MISR_CMP_EN
    assign MISMATCH   = mismatch_q;
    assign PASS_CNT   = passCnt_q;
`endif

endmodule
